// File: rtl/sqroot_seq_if.sv
// Valid/ready bundle for sqroot_seq: argument channel in, result channel out.
interface sqroot_seq_if #(
  parameter int NBITS = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [NBITS-1:0] arg;
  logic             roundup;
  logic             out_valid;
  logic             out_ready;
  logic [NBITS/2:0] sqroot;
  logic [NBITS/2:0] remainder;

  modport master (
    output in_valid, arg, roundup, out_ready,
    input  in_ready, out_valid, sqroot, remainder
  );

  modport slave (
    input  in_valid, arg, roundup, out_ready,
    output in_ready, out_valid, sqroot, remainder
  );
endinterface

// File: rtl/sqroot_seq.sv
// Sequential integer square root, one root bit per clock (restoring recurrence),
// with optional round-to-nearest applied in a final ROUND cycle.
module sqroot_seq #(
  parameter int NBITS = 8
) (
  input  logic         clk,
  input  logic         rst,
  sqroot_seq_if.slave  bus
);
  localparam int unsigned H  = NBITS / 2;
  localparam int unsigned CW = (H > 1) ? $clog2(H) : 1;

  typedef enum logic [1:0] {IDLE, CALC, ROUND, DONE} state_e;

  state_e           state_q, state_d;
  logic [NBITS-1:0] arg_q, arg_d;
  logic             rnd_q, rnd_d;
  logic [H:0]       rem_q, rem_d;
  logic [H-1:0]     root_q, root_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [H:0]       sqroot_q, sqroot_d;
  logic [H:0]       remainder_q, remainder_d;

  logic [1:0]       pair;
  logic [H+2:0]     cand;
  logic [H+2:0]     sub;
  logic [H:0]       diff;
  logic             take;
  logic             inc;

  always_comb begin
    state_d     = state_q;
    arg_d       = arg_q;
    rnd_d       = rnd_q;
    rem_d       = rem_q;
    root_d      = root_q;
    cnt_d       = cnt_q;
    sqroot_d    = sqroot_q;
    remainder_d = remainder_q;

    pair = arg_q[NBITS-1 -: 2];
    cand = {rem_q, pair};
    sub  = {1'b0, root_q, 2'b01};
    // Sign test of the full-width trial done as a compare; a kept difference
    // is bounded by 2*root, so its low H+1 bits are exact.
    take = (cand >= sub);
    diff = cand[H:0] - sub[H:0];
    inc  = rnd_q & (rem_q > {1'b0, root_q});

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          arg_d   = bus.arg;
          rnd_d   = bus.roundup;
          rem_d   = '0;
          root_d  = '0;
          cnt_d   = CW'(H - 1);
          state_d = CALC;
        end
      end
      CALC: begin
        if (take) begin
          rem_d  = diff;
          root_d = {root_q[H-2:0], 1'b1};
        end else begin
          rem_d  = cand[H:0];
          root_d = {root_q[H-2:0], 1'b0};
        end
        arg_d = arg_q << 2;
        if (cnt_q == '0) begin
          state_d = ROUND;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ROUND: begin
        sqroot_d    = {1'b0, root_q} + {{H{1'b0}}, inc};
        remainder_d = rem_q;
        state_d     = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      arg_q       <= '0;
      rnd_q       <= 1'b0;
      rem_q       <= '0;
      root_q      <= '0;
      cnt_q       <= '0;
      sqroot_q    <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      arg_q       <= arg_d;
      rnd_q       <= rnd_d;
      rem_q       <= rem_d;
      root_q      <= root_d;
      cnt_q       <= cnt_d;
      sqroot_q    <= sqroot_d;
      remainder_q <= remainder_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sqroot    = sqroot_q;
  assign bus.remainder = remainder_q;
endmodule

// File: tb/tb_sqroot_seq.sv
// Self-checking bench for sqroot_seq at NBITS=8 and NBITS=16 against an
// arithmetic square-root reference.
module tb_sqroot_seq;
  logic clk;
  logic rst;

  sqroot_seq_if #(.NBITS(8))  b8 ();
  sqroot_seq_if #(.NBITS(16)) b16 ();

  sqroot_seq #(.NBITS(8))  dut8  (.clk(clk), .rst(rst), .bus(b8.slave));
  sqroot_seq #(.NBITS(16)) dut16 (.clk(clk), .rst(rst), .bus(b16.slave));

  int unsigned checks   = 0;
  int unsigned failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Floor root by search; nearest root chosen by comparing 4*a with (2f+1)^2.
  function automatic void ref_sqrt(input int unsigned a, input bit r,
                                   output int unsigned s, output int unsigned rm);
    int unsigned f = 0;
    while ((f + 1) * (f + 1) <= a) f++;
    rm = a - f * f;
    s  = (r && (4 * a > (2 * f + 1) * (2 * f + 1))) ? f + 1 : f;
  endfunction

  function automatic bit rdy(input bit w);
    return w ? b16.in_ready : b8.in_ready;
  endfunction
  function automatic bit vld(input bit w);
    return w ? b16.out_valid : b8.out_valid;
  endfunction
  function automatic int unsigned sq(input bit w);
    return w ? 32'(b16.sqroot) : 32'(b8.sqroot);
  endfunction
  function automatic int unsigned rmd(input bit w);
    return w ? 32'(b16.remainder) : 32'(b8.remainder);
  endfunction

  task automatic drive_in(input bit w, input bit v, input int unsigned a, input bit r);
    if (w) begin
      b16.in_valid = v; b16.arg = 16'(a); b16.roundup = r;
    end else begin
      b8.in_valid = v; b8.arg = 8'(a); b8.roundup = r;
    end
  endtask

  task automatic set_oready(input bit w, input bit v);
    if (w) b16.out_ready = v;
    else   b8.out_ready  = v;
  endtask

  task automatic xact(input bit w, input int unsigned a, input bit r,
                      input int unsigned stall, input bit pulse,
                      output int unsigned s, output int unsigned rm);
    int unsigned n;
    int unsigned lat;
    int unsigned s0;
    int unsigned r0;
    n = 0;
    @(negedge clk);
    while (!rdy(w) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", 32'(rdy(w)), 1);
    drive_in(w, 1'b1, a, r);
    @(negedge clk);
    drive_in(w, 1'b0, $urandom, 1'($urandom));
    lat = 0;
    while (!vld(w) && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, w ? 9 : 5);
    chk("in_ready_busy", 32'(rdy(w)), 0);
    s0 = sq(w);
    r0 = rmd(w);
    for (int unsigned k = 0; k < stall; k++) begin
      if (pulse && k == stall / 2) drive_in(w, 1'b1, $urandom, 1'($urandom));
      @(negedge clk);
      drive_in(w, 1'b0, $urandom, 1'($urandom));
      chk("stall_valid", 32'(vld(w)), 1);
      chk("stall_in_ready", 32'(rdy(w)), 0);
      chk("stall_sqroot", sq(w), s0);
      chk("stall_remainder", rmd(w), r0);
    end
    set_oready(w, 1'b1);
    @(negedge clk);
    set_oready(w, 1'b0);
    chk("post_out_valid", 32'(vld(w)), 0);
    chk("post_in_ready", 32'(rdy(w)), 1);
    s  = s0;
    rm = r0;
  endtask

  task automatic check_model(input bit w, input int unsigned a, input bit r, input int unsigned stall);
    int unsigned s, rm, es, erm;
    xact(w, a, r, stall, 1'b0, s, rm);
    ref_sqrt(a, r, es, erm);
    chk(w ? "sqroot16" : "sqroot8", s, es);
    chk(w ? "remainder16" : "remainder8", rm, erm);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin : main
    int unsigned s, rm, n;
    rst = 1'b1;
    drive_in(1'b0, 1'b0, 0, 1'b0);
    drive_in(1'b1, 1'b0, 0, 1'b0);
    set_oready(1'b0, 1'b0);
    set_oready(1'b1, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", 32'(b8.in_ready), 1);
    chk("rst_out_valid", 32'(b8.out_valid), 0);
    chk("rst_sqroot", 32'(b8.sqroot), 0);
    chk("rst_remainder", 32'(b8.remainder), 0);
    chk("rst_in_ready16", 32'(b16.in_ready), 1);

    xact(1'b0, 0, 1'b0, 0, 1'b0, s, rm);
    chk("zero_sqroot", s, 0);   chk("zero_rem", rm, 0);
    xact(1'b0, 255, 1'b0, 0, 1'b0, s, rm);
    chk("a255_floor", s, 15);   chk("a255_floor_rem", rm, 30);
    xact(1'b0, 255, 1'b1, 0, 1'b0, s, rm);
    chk("a255_round", s, 16);   chk("a255_round_rem", rm, 30);
    xact(1'b0, 72, 1'b1, 1, 1'b0, s, rm);
    chk("a72_round", s, 8);     chk("a72_rem", rm, 8);
    xact(1'b0, 73, 1'b1, 2, 1'b0, s, rm);
    chk("a73_round", s, 9);     chk("a73_rem", rm, 9);
    xact(1'b0, 200, 1'b0, 10, 1'b1, s, rm);
    chk("bp_sqroot", s, 14);    chk("bp_rem", rm, 4);

    // Reset while iterating.
    @(negedge clk);
    drive_in(1'b0, 1'b1, 100, 1'b0);
    @(negedge clk);
    drive_in(1'b0, 1'b0, 0, 1'b0);
    @(negedge clk);
    pulse_reset();
    chk("rcalc_out_valid", 32'(b8.out_valid), 0);
    chk("rcalc_sqroot", 32'(b8.sqroot), 0);
    chk("rcalc_in_ready", 32'(b8.in_ready), 1);

    // Reset while holding a result.
    drive_in(1'b0, 1'b1, 50, 1'b1);
    @(negedge clk);
    drive_in(1'b0, 1'b0, 0, 1'b0);
    n = 0;
    while (!b8.out_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("rdone_reached", 32'(b8.out_valid), 1);
    chk("rdone_pre_sqroot", 32'(b8.sqroot), 7);
    pulse_reset();
    chk("rdone_out_valid", 32'(b8.out_valid), 0);
    chk("rdone_sqroot", 32'(b8.sqroot), 0);
    chk("rdone_remainder", 32'(b8.remainder), 0);
    chk("rdone_in_ready", 32'(b8.in_ready), 1);
    xact(1'b0, 16, 1'b0, 0, 1'b0, s, rm);
    chk("a16_sqroot", s, 4);    chk("a16_rem", rm, 0);

    for (int unsigned a = 0; a < 256; a++) begin
      for (int unsigned r = 0; r < 2; r++) begin
        check_model(1'b0, a, 1'(r), $urandom_range(0, 3));
      end
    end

    xact(1'b1, 65535, 1'b0, 0, 1'b0, s, rm);
    chk("a65535_floor", s, 255); chk("a65535_floor_rem", rm, 510);
    xact(1'b1, 65535, 1'b1, 1, 1'b0, s, rm);
    chk("a65535_round", s, 256); chk("a65535_round_rem", rm, 510);
    for (int unsigned i = 0; i < 150; i++) begin
      check_model(1'b1, $urandom_range(0, 65535), 1'($urandom), $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
